// File: rtl/iter_shifter_if.sv
// Request/result handshake bundle for the iterative shift coprocessor.
interface iter_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [1:0]       op;
  logic [AMTW-1:0]  amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sout;
  logic             busy;

  modport master (
    output in_valid, in, op, amt, out_ready,
    input  in_ready, out_valid, sout, busy
  );

  modport slave (
    input  in_valid, in, op, amt, out_ready,
    output in_ready, out_valid, sout, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: applies pass/LSL/LSR/ASR one bit per clock until the
// requested amount is consumed, with valid/ready handshakes on both sides.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AMTW-1:0] CNT_ONE  = {{(AMTW-1){1'b0}}, 1'b1};
  localparam logic [AMTW-1:0] CNT_ZERO = {AMTW{1'b0}};

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [AMTW-1:0]  r_cnt;
  logic [1:0]       r_op;
  logic             w_accept;
  logic             w_skip;

  function automatic logic [WIDTH-1:0] onebit(input logic [1:0] f_op,
                                              input logic [WIDTH-1:0] f_d);
    logic [WIDTH-1:0] f_r;
    case (f_op)
      2'b01:   f_r = {f_d[WIDTH-2:0], 1'b0};
      2'b10:   f_r = {1'b0, f_d[WIDTH-1:1]};
      2'b11:   f_r = {f_d[WIDTH-1], f_d[WIDTH-1:1]};
      default: f_r = f_d;
    endcase
    return f_r;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_skip   = (bus.amt == CNT_ZERO) || (bus.op == 2'b00);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; DONE always returns to IDLE so a take and an accept never share an edge
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_next = w_skip ? S_DONE : S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_ONE) begin
          w_next = S_DONE;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from state only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.sout      = r_data;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_SHIFT: bus.busy      = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Operand latch and per-step shift; the count parks at 1 rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= {WIDTH{1'b0}};
      r_cnt  <= CNT_ZERO;
      r_op   <= 2'b00;
    end else if (w_accept) begin
      r_data <= bus.in;
      r_cnt  <= bus.amt;
      r_op   <= bus.op;
    end else if (r_state == S_SHIFT) begin
      r_data <= onebit(r_op, r_data);
      if (r_cnt != CNT_ONE) begin
        r_cnt <= r_cnt - CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_data <= r_data;
      r_cnt  <= r_cnt;
      r_op   <= r_op;
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed vectors plus randomized
// requests compared against an arithmetic reference of the shift rules.
module tb_iter_shifter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  iter_shifter_if #(.WIDTH(16), .AMTW(4)) bus ();

  iter_shifter #(.WIDTH(16), .AMTW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-amount shift in one step, straight from the op definitions
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                            input logic [3:0] a);
    logic signed [15:0] s;
    s = d;
    case (o)
      2'b01:   return d << a;
      2'b10:   return d >> a;
      2'b11:   return s >>> a;
      default: return d;
    endcase
  endfunction

  // Issue one request from IDLE, check latency/result, optionally stall the consumer
  task automatic do_req(input logic [15:0] din, input logic [1:0] dop, input logic [3:0] damt,
                        input logic [15:0] exp, input int hold);
    int lat;
    int lat_exp;
    lat_exp = (dop == 2'b00 || damt == 4'd0) ? 0 : int'(damt);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in        = din;
    bus.op        = dop;
    bus.amt       = damt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in       = 16'($urandom);
    bus.op       = 2'($urandom);
    bus.amt      = 4'($urandom);
    if (lat_exp > 1) check("busy_shift", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    check("sout", 32'(bus.sout), 32'(exp));
    check("busy_done", 32'(bus.busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in       = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sout", 32'(bus.sout), 32'(exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_sout", 32'(bus.sout), 32'(exp));
  endtask

  initial begin
    logic       seen;
    logic [15:0] rd;
    logic [1:0]  ro;
    logic [3:0]  ra;
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = 16'h0000;
    bus.op        = 2'b00;
    bus.amt       = 4'd0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sout", 32'(bus.sout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_req(16'hF0CF, 2'b01, 4'd4,  16'h0CF0, 0);
    do_req(16'hF0CF, 2'b10, 4'd4,  16'h0F0C, 0);
    do_req(16'hF0CF, 2'b11, 4'd4,  16'hFF0C, 0);
    do_req(16'hF0CF, 2'b00, 4'd7,  16'hF0CF, 0);
    do_req(16'hF0CF, 2'b01, 4'd0,  16'hF0CF, 0);
    do_req(16'hF0CF, 2'b11, 4'd15, 16'hFFFF, 0);
    do_req(16'hF0CF, 2'b01, 4'd15, 16'h8000, 0);
    do_req(16'hF0CF, 2'b10, 4'd15, 16'h0001, 0);
    do_req(16'h1234, 2'b10, 4'd3,  16'h0246, 5);

    // Abort mid-shift: reset must wipe the result without an out_valid pulse
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in        = 16'hF0CF;
    bus.op        = 2'b01;
    bus.amt       = 4'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sout", 32'(bus.sout), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    do_req(16'h0001, 2'b01, 4'd3, 16'h0008, 0);

    for (int k = 0; k < 40; k++) begin
      rd = 16'($urandom);
      ro = 2'($urandom);
      ra = 4'($urandom);
      do_req(rd, ro, ra, ref_shift(rd, ro, ra), ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
